// File: rtl/dram_dump.sv
// Streams a contiguous region of a combinational-read data memory out over a
// valid/ready byte interface, one byte every two cycles at full throughput.
module dram_dump #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_ext_addr;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic              w_handshake;
    logic              w_start_run;

    assign w_handshake = (r_state == S_SEND) && r_out_valid && out_ready;
    assign w_start_run = (r_state == S_IDLE) && start && (length != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (length == '0) ? S_DONE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                if (w_handshake) begin
                    w_next = r_out_last ? S_DONE : S_SETTLE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Address and remaining count advance only after a byte is accepted, so
    // backpressure freezes everything the consumer can observe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_addr  <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_start_run) begin
                r_ext_addr <= base_addr;
                r_count    <= length;
            end
            if (r_state == S_SETTLE) begin
                r_out_data  <= ext_data;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_count == ADDR_W'(1));
            end
            if (w_handshake) begin
                r_out_valid <= 1'b0;
                if (!r_out_last) begin
                    r_ext_addr <= r_ext_addr + ADDR_W'(1);
                    r_count    <= r_count - ADDR_W'(1);
                end
            end
        end
    end

    assign ext_addr  = r_ext_addr;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule
